// File: rtl/risc_v_pkg.sv
// Shared types and constants for the risc_v core front end.
package risc_v_pkg;

  localparam int          ADDRESS_WIDTH_DEF = 32;
  localparam int          DATA_WIDTH_DEF    = 32;
  localparam logic [31:0] RESET_PC_DEF      = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    KILL  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall beats load; otherwise a bubble.
module if_id_reg
  import risc_v_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     load,
  input  logic [DATA_WIDTH-1:0]    instr,
  input  logic [ADDRESS_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0]    InstrD,
  output logic [ADDRESS_WIDTH-1:0] PCD,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
  output logic                     ValidD
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (flush) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (stall) begin
      InstrD   <= InstrD;
    end else if (load) begin
      InstrD   <= instr;
      PCD      <= pc;
      PCPlus4D <= pc + ADDRESS_WIDTH'(4);
      ValidD   <= 1'b1;
    end else begin
      // Nothing to hand over this edge: decode sees a bubble.
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, talks to instruction memory, handles
// redirects and stalls, and feeds the IF/ID register.
module fetch_stage
  import risc_v_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int                     DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = ADDRESS_WIDTH'(RESET_PC_DEF)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     StallF,
  input  logic                     StallD,
  input  logic                     FlushD,
  input  logic                     PCSrcE,
  input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [DATA_WIDTH-1:0]    InstrD,
  output logic [ADDRESS_WIDTH-1:0] PCD,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
  output logic                     ValidD,
  output logic                     FetchBusy,
  output fetch_state_t             state_dbg
);

  // Memory handshake: imem_req is held with imem_addr stable until the memory
  // raises imem_ack; a word is transferred on every edge where req & ack are
  // both high (ack may come in the same cycle req rises). Dropping req
  // without ack (reset) abandons the request.

  fetch_state_t             state;
  logic [ADDRESS_WIDTH-1:0] pcf;
  logic [ADDRESS_WIDTH-1:0] pcf_plus4;
  logic [ADDRESS_WIDTH-1:0] target;
  logic [ADDRESS_WIDTH-1:0] redir_pc;
  logic [DATA_WIDTH-1:0]    hold_buf;
  logic                     hold_valid;
  logic                     ack;
  logic                     deliver;
  logic [DATA_WIDTH-1:0]    deliver_word;

  assign pcf_plus4 = pcf + ADDRESS_WIDTH'(4);
  assign target    = {PCTargetE[ADDRESS_WIDTH-1:2], 2'b00};

  assign imem_req  = rst & (state != HOLD);
  assign imem_addr = pcf;
  assign ack       = imem_req & imem_ack;
  assign FetchBusy = imem_req & ~imem_ack;
  assign state_dbg = state;

  assign deliver      = ~PCSrcE & ~StallF &
                        (((state == FETCH) & ack) | ((state == HOLD) & hold_valid));
  assign deliver_word = (state == HOLD) ? hold_buf : imem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH;
      pcf        <= RESET_PC;
      redir_pc   <= '0;
      hold_buf   <= DATA_WIDTH'(NOP_INSTR);
      hold_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (PCSrcE) begin
            if (ack) begin
              pcf <= target;
            end else begin
              redir_pc <= target;
              state    <= KILL;
            end
          end else if (ack) begin
            if (!StallF) begin
              pcf <= pcf_plus4;
            end else begin
              hold_buf   <= imem_rdata;
              hold_valid <= 1'b1;
              state      <= HOLD;
            end
          end
        end
        KILL: begin
          // The stale request must complete before the new PC can be issued.
          if (PCSrcE) redir_pc <= target;
          if (ack) begin
            pcf   <= PCSrcE ? target : redir_pc;
            state <= FETCH;
          end
        end
        HOLD: begin
          if (PCSrcE) begin
            hold_valid <= 1'b0;
            pcf        <= target;
            state      <= FETCH;
          end else if (!StallF) begin
            hold_valid <= 1'b0;
            pcf        <= pcf_plus4;
            state      <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_id_reg #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .stall   (StallD),
    .flush   (FlushD),
    .load    (deliver),
    .instr   (deliver_word),
    .pc      (pcf),
    .InstrD  (InstrD),
    .PCD     (PCD),
    .PCPlus4D(PCPlus4D),
    .ValidD  (ValidD)
  );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Pipelined instruction-fetch stage for the 5-stage risc_v core. It owns the fetch PC and issues requests to instruction memory over a req/ack handshake that tolerates wait states. It holds a fetched word while the pipeline stalls, applies branch/jump redirects from Execute, and drives the IF/ID pipeline register that feeds the decode block.

Parameters:
ADDRESS_WIDTH, 32, width of PC and instruction-memory address
DATA_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
StallF  in  1  hold PC / do not consume new fetch (hazard unit)
StallD  in  1  hold IF/ID register
FlushD  in  1  replace IF/ID contents with bubble
PCSrcE  in  1  redirect taken in Execute
PCTargetE  in  ADDRESS_WIDTH  redirect target
imem_req  out  1  fetch request
imem_addr  out  ADDRESS_WIDTH  fetch address, equals PCF
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  DATA_WIDTH  fetched instruction
InstrD  out  DATA_WIDTH  IF/ID instruction
PCD  out  ADDRESS_WIDTH  IF/ID PC
PCPlus4D  out  ADDRESS_WIDTH  IF/ID PC+4
ValidD  out  1  IF/ID holds a real instruction
FetchBusy  out  1  imem_req & ~imem_ack, to hazard unit

Behaviour:
- Reset (rst=0, async): PCF=RESET_PC, state=FETCH, InstrD=NOP (32'h0000_0013), PCD=0, PCPlus4D=0, ValidD=0, hold buffer invalid. imem_req=0 while rst=0.
- imem_req = rst & (state != HOLD); imem_addr = PCF, stable until ack. Ack may arrive in the request cycle (zero wait states).
- PC arithmetic: modulo 2^ADDRESS_WIDTH; 0xFFFF_FFFC+4 = 0. PCTargetE[1:0] forced to 00.
- "Deliver W" = IF/ID loads {W, PCF, PCF+4}, ValidD=1.
- IF/ID priority per edge: FlushD (bubble: NOP, ValidD=0) > StallD (hold) > deliver > bubble (no word to deliver).
- StallF=0 with StallD=1 is illegal; bench asserts it never occurs.
- FETCH state:
  - PCSrcE & ack: discard word, PCF<=target, stay FETCH.
  - PCSrcE & ~ack: redir_pc<=target, go KILL.
  - ~PCSrcE & ack & ~StallF: deliver imem_rdata, PCF<=PCF+4.
  - ~PCSrcE & ack & StallF: buffer<=imem_rdata, go HOLD.
  - ~ack: IF/ID bubble unless stalled or flushed; PCF unchanged.
- KILL state: imem_req=1 at old PCF. A further PCSrcE overwrites redir_pc. On ack: discard word, PCF<=redir_pc (latest), go FETCH. If PCSrcE and ack coincide, the new PCTargetE wins. IF/ID gets a bubble each cycle.
- HOLD state: imem_req=0.
  - PCSrcE: drop buffer, PCF<=target, go FETCH (PCSrcE beats StallF).
  - ~StallF: deliver buffer, PCF<=PCF+4, go FETCH.
  - Otherwise hold.
- Latency: with zero-wait memory and no hazards, one instruction per cycle. The instruction at PCF appears on InstrD the edge after ack.
- Reset mid-transaction: outstanding request abandoned. The memory must tolerate req dropping without ack.

Decomposition:
- risc_v_pkg:
  - NOP_INSTR = 32'h0000_0013
  - fetch_state_t enum {FETCH, KILL, HOLD}
  - RESET_PC default
- Sub-module if_id_reg: IF/ID register with stall/flush priority and async active-low reset. The FSM, PC, and hold buffer stay in fetch_stage.

Test Plan:
- Reset release, ack every cycle, no hazards → imem_addr 0,4,8,12 on consecutive cycles; PCD 0,4,8 one cycle later; ValidD=1 from second edge.
- Ack delayed 3 cycles at PC=8 → imem_addr stays 8 for 4 cycles, FetchBusy=1 for 3. IF/ID shows 3 bubbles (InstrD=0x13, ValidD=0), then PCD=8.
- Ack at PC=0x10 with StallF=StallD=1 for 2 cycles → state HOLD, imem_req=0. When stalls drop, InstrD=buffered word, PCD=0x10, next imem_addr=0x14.
- PCSrcE=1, PCTargetE=0x40 while request at 0x20 is waiting; ack 2 cycles later → 0x20 word never reaches ValidD=1, next imem_addr=0x40.
- PCSrcE=1 with PCTargetE=0x103 in HOLD with StallF=1 → buffer dropped, imem_addr=0x100 next cycle.
- PCF=0xFFFF_FFFC, ack → next imem_addr=0x0. Assert rst=0 mid-wait → all outputs at reset values immediately.
